// File: rtl/vga_pkg.sv
// Shared VGA constants: source selects, colours, screen size and the
// write-mux state encoding.
package vga_pkg;

  typedef enum logic [1:0] {
    SEL_GAME = 2'd0,
    SEL_LOSE = 2'd1,
    SEL_WIN  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } mux_state_e;

  localparam logic [8:0] BLACK = 9'b000_000_000;
  localparam logic [8:0] RED   = 9'b111_000_000;

  localparam int XSCREEN = 640;
  localparam int YSCREEN = 480;

endpackage

// File: rtl/rect_sweep.sv
// Raster counter over a width x height rectangle: cx runs fastest, cy steps
// on each cx wrap. 'last' flags the bottom-right pixel of the rectangle.
module rect_sweep (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic       advance,
  input  logic [9:0] width,
  input  logic [8:0] height,
  output logic [9:0] cx,
  output logic [8:0] cy,
  output logic       last
);

  logic x_end;

  assign x_end = (cx == width - 10'd1);
  assign last  = x_end && (cy == height - 9'd1);

  always_ff @(posedge Clock) begin
    if (!Resetn || start) begin
      cx <= 10'd0;
      cy <= 9'd0;
    end else if (advance) begin
      if (x_end) begin
        cx <= 10'd0;
        cy <= last ? 9'd0 : cy + 9'd1;
      end else begin
        cx <= cx + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_write_mux.sv
// Sole driver of the VGA adapter write port: registered pass-through of the
// selected source, plus a built-in rectangle-clear sweep.
module vga_write_mux
  import vga_pkg::*;
#(
  parameter int         CLEAR_X0    = 0,
  parameter int         CLEAR_Y0    = 0,
  parameter int         CLEAR_W     = 640,
  parameter int         CLEAR_H     = 480,
  parameter logic [8:0] CLEAR_COLOR = 9'b000_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [1:0] sel,
  input  logic       clear_req,
  input  logic [9:0] s0_x,
  input  logic [8:0] s0_y,
  input  logic [8:0] s0_color,
  input  logic       s0_write,
  input  logic [9:0] s1_x,
  input  logic [8:0] s1_y,
  input  logic [8:0] s1_color,
  input  logic       s1_write,
  input  logic [9:0] s2_x,
  input  logic [8:0] s2_y,
  input  logic [8:0] s2_color,
  input  logic       s2_write,
  output logic [9:0] VGA_x,
  output logic [8:0] VGA_y,
  output logic [8:0] VGA_color,
  output logic       VGA_write,
  output logic       clear_busy,
  output logic       clear_done,
  output logic       dropped
);

  localparam logic [9:0] X0 = 10'(CLEAR_X0);
  localparam logic [8:0] Y0 = 9'(CLEAR_Y0);
  localparam logic [9:0] CW = 10'(CLEAR_W);
  localparam logic [8:0] CH = 9'(CLEAR_H);

  mux_state_e state_q, state_d;
  sel_e       sel_s;
  logic [1:0] sel_q;
  logic [9:0] src_x, cx;
  logic [8:0] src_y, src_color, cy;
  logic       src_write, sweep_start, sweep_adv, sweep_last;

  assign sel_s = sel_e'(sel);

  // SEL_NONE still routes s0 coordinates, only the strobe is suppressed.
  always_comb begin
    src_x     = s0_x;
    src_y     = s0_y;
    src_color = s0_color;
    src_write = 1'b0;
    case (sel_s)
      SEL_GAME: src_write = s0_write;
      SEL_LOSE: begin
        src_x     = s1_x;
        src_y     = s1_y;
        src_color = s1_color;
        src_write = s1_write;
      end
      SEL_WIN: begin
        src_x     = s2_x;
        src_y     = s2_y;
        src_color = s2_color;
        src_write = s2_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= ST_PASS;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    sweep_adv   = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          sweep_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        sweep_adv = 1'b1;
        if (sweep_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_PASS;
      default: state_d = ST_PASS;
    endcase
  end

  rect_sweep u_sweep (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (sweep_start),
    .advance (sweep_adv),
    .width   (CW),
    .height  (CH),
    .cx      (cx),
    .cy      (cy),
    .last    (sweep_last)
  );

  // Select history follows sel in every state so returning from a sweep
  // never produces a spurious bubble.
  always_ff @(posedge Clock) begin
    if (!Resetn) sel_q <= 2'd0;
    else         sel_q <= sel;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      VGA_x      <= 10'd0;
      VGA_y      <= 9'd0;
      VGA_color  <= 9'd0;
      VGA_write  <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state_q)
        ST_PASS: begin
          if (clear_req) begin
            VGA_write  <= 1'b0;
            clear_busy <= 1'b1;
            dropped    <= 1'b0;
          end else begin
            VGA_x     <= src_x;
            VGA_y     <= src_y;
            VGA_color <= src_color;
            VGA_write <= src_write && (sel == sel_q);
          end
        end
        ST_CLEAR: begin
          VGA_x     <= X0 + cx;
          VGA_y     <= Y0 + cy;
          VGA_color <= CLEAR_COLOR;
          VGA_write <= 1'b1;
          if (src_write) dropped <= 1'b1;
        end
        ST_DONE: begin
          VGA_write  <= 1'b0;
          clear_busy <= 1'b0;
          clear_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_mux.sv
// Bench for vga_write_mux: directed scenarios plus a randomized run, checked
// against a sweep-index reference model.
module tb_vga_write_mux;
  import vga_pkg::*;

  localparam int         X0 = 100;
  localparam int         Y0 = 50;
  localparam int         W  = 4;
  localparam int         H  = 2;
  localparam logic [8:0] CC = BLACK;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       clear_req = 1'b0;
  logic [9:0] s0_x = '0, s1_x = '0, s2_x = '0;
  logic [8:0] s0_y = '0, s1_y = '0, s2_y = '0;
  logic [8:0] s0_color = '0, s1_color = '0, s2_color = '0;
  logic       s0_write = 1'b0, s1_write = 1'b0, s2_write = 1'b0;
  logic [9:0] VGA_x;
  logic [8:0] VGA_y, VGA_color;
  logic       VGA_write, clear_busy, clear_done, dropped;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 pass, 1 sweeping, 2 done; sweep position is a
  // linear pixel index.
  int         m_mode = 0;
  int         m_idx = 0;
  logic [1:0] m_prev_sel = 2'd0;
  logic [9:0] m_x = '0;
  logic [8:0] m_y = '0, m_color = '0;
  logic       m_write = 0, m_busy = 0, m_done = 0, m_dropped = 0;

  logic [18:0] exp_q[$];

  vga_write_mux #(
    .CLEAR_X0(X0), .CLEAR_Y0(Y0), .CLEAR_W(W), .CLEAR_H(H), .CLEAR_COLOR(CC)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .sel(sel), .clear_req(clear_req),
    .s0_x(s0_x), .s0_y(s0_y), .s0_color(s0_color), .s0_write(s0_write),
    .s1_x(s1_x), .s1_y(s1_y), .s1_color(s1_color), .s1_write(s1_write),
    .s2_x(s2_x), .s2_y(s2_y), .s2_color(s2_color), .s2_write(s2_write),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
    .clear_busy(clear_busy), .clear_done(clear_done), .dropped(dropped)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] dut_vec();
    return {VGA_x, VGA_y, VGA_color, VGA_write, clear_busy, clear_done, dropped};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {m_x, m_y, m_color, m_write, m_busy, m_done, m_dropped};
  endfunction

  task automatic model_edge();
    logic [2:0] w;
    int s;
    w = {s2_write, s1_write, s0_write};
    s = int'(sel);
    if (!Resetn) begin
      m_x = '0; m_y = '0; m_color = '0;
      m_write = 0; m_busy = 0; m_done = 0; m_dropped = 0;
      m_mode = 0; m_idx = 0; m_prev_sel = 2'd0;
    end else begin
      m_done = 0;
      if (m_mode == 1) begin
        m_x = 10'(X0 + m_idx % W);
        m_y = 9'(Y0 + m_idx / W);
        m_color = CC;
        m_write = 1;
        m_busy = 1;
        if (s != 3 && w[s]) m_dropped = 1;
        m_idx++;
        if (m_idx == W * H) m_mode = 2;
      end else if (m_mode == 2) begin
        m_write = 0; m_busy = 0; m_done = 1; m_mode = 0;
      end else if (clear_req) begin
        m_mode = 1; m_idx = 0; m_busy = 1; m_dropped = 0; m_write = 0;
      end else begin
        case (s)
          1:       begin m_x = s1_x; m_y = s1_y; m_color = s1_color; end
          2:       begin m_x = s2_x; m_y = s2_y; m_color = s2_color; end
          default: begin m_x = s0_x; m_y = s0_y; m_color = s0_color; end
        endcase
        m_write = (s != 3) && w[s] && (sel == m_prev_sel);
      end
      m_prev_sel = sel;
    end
  endtask

  // One active edge: model consumes the inputs present at the edge, then
  // outputs are sampled 1ns later.
  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic rand_sources(input logic w0, input logic w1, input logic w2);
    s0_x = 10'($urandom_range(0, 1023)); s0_y = 9'($urandom_range(0, 511));
    s1_x = 10'($urandom_range(0, 1023)); s1_y = 9'($urandom_range(0, 511));
    s2_x = 10'($urandom_range(0, 1023)); s2_y = 9'($urandom_range(0, 511));
    s0_color = 9'($urandom_range(0, 511));
    s1_color = 9'($urandom_range(0, 511));
    s2_color = 9'($urandom_range(0, 511));
    s0_write = w0; s1_write = w1; s2_write = w2;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    rand_sources(1, 1, 1);
    sel = 2'd2;
    tick();
    tick();
    checks++;
    if (dut_vec() !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", dut_vec(), 32'd0);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dut_vec(), exp_vec());
    end
    Resetn = 1'b1;
    sel = 2'd0;
    rand_sources(0, 0, 0);
  endtask

  task automatic test_pass_through();
    sel = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    rand_sources(1, 0, 1);
    s1_x = 10'd10; s1_y = 9'd20; s1_color = 9'h1C0; s1_write = 1'b1;
    tick();
    checks++;
    if ({VGA_x, VGA_y, VGA_color, VGA_write} !== {10'd10, 9'd20, 9'h1C0, 1'b1}) begin
      errors++;
      $display("FAIL pass_s1: got (%0d,%0d,%h,%b) expected (10,20,1c0,1)",
               VGA_x, VGA_y, VGA_color, VGA_write);
    end
    for (int i = 0; i < 10; i++) begin
      rand_sources(1, 0, 1);
      tick();
      checks++;
      if (VGA_write !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pass_others_blocked: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 30; i++) begin
      rand_sources(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pass_random: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_select_bubble();
    sel = 2'd0;
    rand_sources(1, 1, 1);
    tick();
    tick();
    sel = 2'd1;
    rand_sources(1, 1, 1);
    tick();
    checks++;
    if (VGA_write !== 1'b0 || VGA_x !== s1_x || VGA_color !== s1_color) begin
      errors++;
      $display("FAIL bubble_cycle: got write=%b x=%0d expected write=0 x=%0d",
               VGA_write, VGA_x, s1_x);
    end
    rand_sources(1, 1, 1);
    tick();
    checks++;
    if ({VGA_x, VGA_y, VGA_color, VGA_write} !== {s1_x, s1_y, s1_color, 1'b1}) begin
      errors++;
      $display("FAIL bubble_after: got (%0d,%0d,%h,%b) expected (%0d,%0d,%h,1)",
               VGA_x, VGA_y, VGA_color, VGA_write, s1_x, s1_y, s1_color);
    end
  endtask

  task automatic test_sel_none();
    sel = 2'd3;
    for (int i = 0; i < 20; i++) begin
      rand_sources(1, 1, 1);
      tick();
      checks++;
      if (VGA_write !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sel_none: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clear_sweep();
    int writes;
    sel = 2'd1;
    rand_sources(0, 0, 0);
    tick();
    exp_q.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({10'(X0 + xx), 9'(Y0 + yy)});
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if ({VGA_write, clear_busy, clear_done, dropped} !== 4'b0100) begin
      errors++;
      $display("FAIL sweep_start: got w/b/d/dr=%b%b%b%b expected 0100",
               VGA_write, clear_busy, clear_done, dropped);
    end
    writes = 0;
    for (int c = 1; c <= W * H + 1; c++) begin
      rand_sources(0, (c == 3), 0);
      tick();
      if (VGA_write) begin
        logic [18:0] px;
        writes++;
        px = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({VGA_x, VGA_y} !== px || VGA_color !== CC) begin
          errors++;
          $display("FAIL sweep_pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                   VGA_x, VGA_y, VGA_color, px[18:9], px[8:0], CC);
        end
      end
      checks++;
      if (clear_busy !== (c <= W * H) || clear_done !== (c == W * H + 1) ||
          dropped !== (c >= 3)) begin
        errors++;
        $display("FAIL sweep_flags: cycle %0d got b/d/dr=%b%b%b", c,
                 clear_busy, clear_done, dropped);
      end
    end
    checks++;
    if (writes != W * H || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_count: got %0d writes expected %0d", writes, W * H);
    end
    for (int i = 0; i < 4; i++) begin
      rand_sources(0, 1'($urandom), 0);
      tick();
    end
    checks++;
    if (dropped !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL dropped_sticky: got %h expected %h", dut_vec(), exp_vec());
    end
    rand_sources(0, 0, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL dropped_cleared: got %b expected 0", dropped);
    end
    for (int i = 0; i < W * H + 2; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sweep2_model: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clear_req_held();
    sel = 2'd0;
    rand_sources(0, 0, 0);
    clear_req = 1'b1;
    for (int i = 0; i < W * H + 2; i++) tick();
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_done: got done=%b busy=%b expected 1 0", clear_done, clear_busy);
    end
    tick();
    clear_req = 1'b0;
    checks++;
    if ({VGA_write, clear_busy, clear_done} !== 3'b010) begin
      errors++;
      $display("FAIL held_restart: got w/b/d=%b%b%b expected 010",
               VGA_write, clear_busy, clear_done);
    end
    for (int i = 0; i < W * H + 2; i++) begin
      rand_sources(1'($urandom), 0, 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_model: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen;
    sel = 2'd0;
    rand_sources(0, 0, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    Resetn = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got %h expected %h", dut_vec(), 32'd0);
    end
    Resetn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < W * H + 4; i++) begin
      rand_sources(1, 1'($urandom), 1'($urandom));
      tick();
      if (clear_done) done_seen++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset_model: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (done_seen != 0 || VGA_write !== 1'b1 || VGA_x !== s0_x) begin
      errors++;
      $display("FAIL post_reset_pass: got done_seen=%0d write=%b expected 0 1",
               done_seen, VGA_write);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      clear_req = ($urandom_range(0, 49) == 0);
      Resetn = ($urandom_range(0, 199) != 0);
      rand_sources(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model: cycle %0d got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    Resetn = 1'b1;
    clear_req = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_pass_through();
    test_select_bubble();
    test_sel_none();
    test_clear_sweep();
    test_clear_req_held();
    test_reset_mid_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
